mem_arbiter: RTL and testbench

- Shares the single-port 16-bit synchronous memory between two masters:
  - port 0: the CPU.
  - port 1: a secondary master, such as a program loader, debug port or DMA.
- Sits between the masters and the memory unit in the SoC top.
- Fixed priority to port 0, with a starvation override and a burst lock for port 1.
- Routes one-cycle-latency read data back to whichever master issued the read.

---
 rtl/mem_arbiter_pkg.sv | 9 +
 rtl/mem_arb_starve.sv | 22 ++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared configuration and types for the two-master memory arbiter.
package mem_arbiter_pkg;
  localparam int RAM_SIZE_LOG       = 12;
  localparam int STARVE_MAX_DEFAULT = 8;
  localparam int PORT_CPU           = 0;
  localparam int PORT_AUX           = 1;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;
endpackage

// File: rtl/mem_arb_starve.sv
// Saturating count of consecutive cycles the aux port was requesting but denied.
module mem_arb_starve #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic at_max
);
  localparam logic [7:0] MAX_C = 8'(MAX);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (!req || gnt)  cnt <= '0;
    else if (cnt != MAX_C) cnt <= cnt + 8'd1;
  end

  assign at_max = (cnt == MAX_C);
endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one synchronous single-port memory between
// the CPU (port 0) and an aux master (port 1) with starvation override and lock.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW         = RAM_SIZE_LOG,
  parameter int DW         = 16,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [15:0]   m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [15:0]   m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic          m1_lock_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  output logic          mem_we_o,
  input  logic [DW-1:0] mem_data_i
);
  lock_e lock_q, lock_d;
  logic  at_max, gnt0, gnt1;
  logic  rd_pend_q, rd_sel_q;

  mem_arb_starve #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .req    (m1_req_i),
    .gnt    (gnt1),
    .at_max (at_max)
  );

  // Grants are forced low while reset is held, independent of requests.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_i) begin
      if (lock_q == LOCKED)      gnt1 = m1_req_i;
      else if (at_max && m1_req_i) gnt1 = 1'b1;
      else if (m0_req_i)         gnt0 = 1'b1;
      else                       gnt1 = m1_req_i;
    end
  end

  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      UNLOCKED: if (gnt1 && m1_lock_i) lock_d = LOCKED;
      LOCKED:   if (!m1_lock_i)        lock_d = UNLOCKED;
      default:                         lock_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lock_q <= UNLOCKED;
    else        lock_q <= lock_d;
  end

  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_we_o   = 1'b0;
    if (gnt0) begin
      mem_addr_o = m0_addr_i[AW-1:0];
      mem_data_o = m0_wdata_i;
      mem_we_o   = m0_we_i;
    end else if (gnt1) begin
      mem_addr_o = m1_addr_i[AW-1:0];
      mem_data_o = m1_wdata_i;
      mem_we_o   = m1_we_i;
    end
  end

  // Remember who issued a read so the next-cycle data goes back to them.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_pend_q <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      rd_pend_q <= (gnt0 || gnt1) && !mem_we_o;
      rd_sel_q  <= gnt1;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign m0_rvalid_o = rd_pend_q && (rd_sel_q == 1'(PORT_CPU));
  assign m1_rvalid_o = rd_pend_q && (rd_sel_q == 1'(PORT_AUX));
  assign m0_rdata_o  = mem_data_i;
  assign m1_rdata_o  = mem_data_i;

  generate
    if (AW < 16) begin : g_alias
      logic unused_hi;
      assign unused_hi = ^{m0_addr_i[15:AW], m1_addr_i[15:AW]};
    end
  endgenerate
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus reset/starve/lock sequences,
// with a one-deep scoreboard for read returns.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_i;
  logic m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [15:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [15:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_rd;
  logic mem_we;

  logic [15:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wd), .mem_we_o(mem_we), .mem_data_i(mem_rd)
  );

  // Synchronous single-port memory, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
    mem_rd <= mem[mem_addr];
  end

  typedef struct {
    logic        r0, w0;
    logic [15:0] a0, d0;
    logic        r1, w1;
    logic [15:0] a1, d1;
    logic        lk;
    logic        g0, g1;
    logic [15:0] rd;
  } vec_t;

  typedef struct {
    logic        vld;
    logic        port;
    logic [15:0] data;
  } sbe_t;

  sbe_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic r0, logic w0, logic [15:0] a0, logic [15:0] d0,
                              logic r1, logic w1, logic [15:0] a1, logic [15:0] d1,
                              logic lk, logic g0, logic g1, logic [15:0] rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.lk = lk; v.g0 = g0; v.g1 = g1; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Called at a falling edge: drive, check, then advance to the next falling edge.
  task automatic step(input vec_t v, input string nm);
    logic [AW-1:0] ea;
    logic [15:0]   ed;
    logic          ew;
    sbe_t          e;
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    m1_lock = v.lk;
    #1;
    ea = v.g0 ? v.a0[AW-1:0] : v.g1 ? v.a1[AW-1:0] : '0;
    ed = v.g0 ? v.d0 : v.g1 ? v.d1 : 16'h0;
    ew = v.g0 ? v.w0 : v.g1 ? v.w1 : 1'b0;
    chk({nm, " m0_gnt"}, 32'(m0_gnt), 32'(v.g0));
    chk({nm, " m1_gnt"}, 32'(m1_gnt), 32'(v.g1));
    chk({nm, " mem_we"}, 32'(mem_we), 32'(ew));
    chk({nm, " mem_addr"}, 32'(mem_addr), 32'(ea));
    chk({nm, " mem_data"}, 32'(mem_wd), 32'(ed));
    e = '{vld: 1'b0, port: 1'b0, data: 16'h0};
    if (sb.size() > 0) e = sb.pop_front();
    chk({nm, " m0_rvalid"}, 32'(m0_rvalid), 32'(e.vld && !e.port));
    chk({nm, " m1_rvalid"}, 32'(m1_rvalid), 32'(e.vld && e.port));
    if (e.vld) chk({nm, " rdata"}, 32'(e.port ? m1_rdata : m0_rdata), 32'(e.data));
    if ((v.g0 || v.g1) && !ew) sb.push_back('{vld: 1'b1, port: v.g1, data: v.rd});
    else                       sb.push_back('{vld: 1'b0, port: 1'b0, data: 16'h0});
    @(negedge clk);
  endtask

  // m0 reads 0x0001 continuously; m1 reads 0x0002 until granted on cycle win.
  task automatic starve_run(input int n, input int win, input string nm);
    for (int k = 0; k < n; k++) begin
      logic r1;
      r1 = (win < 0) || (k <= win);
      step(mk(1'b1, 1'b0, 16'h0001, 16'h0, r1, 1'b0, 16'h0002, 16'h0, 1'b0,
              k != win, k == win, (k == win) ? 16'h5555 : 16'hAAAA),
           $sformatf("%s[%0d]", nm, k));
    end
  endtask

  vec_t tbl [10];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0;
    mem[12'h001] = 16'hAAAA;
    mem[12'h002] = 16'h5555;
    mem[12'h010] = 16'hBEEF;

    tbl[0] = mk(1, 0, 16'h0010, 16'h0,    1, 0, 16'h0002, 16'h0,    0, 1, 0, 16'hBEEF);
    tbl[1] = mk(1, 0, 16'h0001, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 0, 16'hAAAA);
    tbl[2] = mk(0, 0, 16'h0,    16'h0,    1, 0, 16'h0002, 16'h0,    0, 0, 1, 16'h5555);
    tbl[3] = mk(1, 1, 16'h0030, 16'h1111, 0, 0, 16'h0,    16'h0,    0, 1, 0, 16'h0);
    tbl[4] = mk(1, 0, 16'h1030, 16'h0,    0, 0, 16'h0,    16'h0,    0, 1, 0, 16'h1111);
    tbl[5] = mk(0, 0, 16'h0,    16'h0,    0, 0, 16'h0,    16'h0,    0, 0, 0, 16'h0);
    tbl[6] = mk(1, 0, 16'h0001, 16'h0,    1, 1, 16'h0040, 16'h2222, 0, 1, 0, 16'hAAAA);
    tbl[7] = mk(0, 0, 16'h0,    16'h0,    1, 1, 16'h0040, 16'h2222, 0, 0, 1, 16'h0);
    tbl[8] = mk(0, 0, 16'h0,    16'h0,    1, 0, 16'h0040, 16'h0,    0, 0, 1, 16'h2222);
    tbl[9] = mk(0, 0, 16'h0,    16'h0,    0, 0, 16'h0,    16'h0,    0, 0, 0, 16'h0);

    // Reset held with both masters requesting; m0 attempts a write that must not land.
    rst_i = 1'b0;
    m0_req = 1; m0_we = 1; m0_addr = 16'h0010; m0_wdata = 16'hDEAD;
    m1_req = 1; m1_we = 0; m1_addr = 16'h0002; m1_wdata = 16'h0; m1_lock = 1;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst m0_gnt", 32'(m0_gnt), 32'd0);
      chk("rst m1_gnt", 32'(m1_gnt), 32'd0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      @(negedge clk);
    end
    rst_i = 1'b1;

    for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("vec%0d", i));

    starve_run(11, 8, "starve");

    step(mk(0, 0, 16'h0,    16'h0, 1, 1, 16'h0020, 16'h1234, 1, 0, 1, 16'h0),    "lockA");
    step(mk(1, 0, 16'h0001, 16'h0, 1, 0, 16'h0020, 16'h0,    1, 0, 1, 16'h1234), "lockB");
    step(mk(1, 0, 16'h0001, 16'h0, 0, 0, 16'h0,    16'h0,    1, 0, 0, 16'h0),    "lockC");
    step(mk(1, 0, 16'h0001, 16'h0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 16'h0),    "lockD");
    step(mk(1, 0, 16'h0001, 16'h0, 0, 0, 16'h0,    16'h0,    0, 1, 0, 16'hAAAA), "lockE");
    step(mk(0, 0, 16'h0,    16'h0, 1, 0, 16'h0020, 16'h0,    1, 0, 1, 16'h1234), "lockF");
    step(mk(1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0,    0, 0, 1, 16'h5555), "lockG");
    step(mk(1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0,    0, 1, 0, 16'hAAAA), "lockH");
    step(mk(0, 0, 16'h0,    16'h0, 1, 0, 16'h0002, 16'h0,    0, 0, 1, 16'h5555), "lockI");

    // Reset while locked must return to unlocked.
    step(mk(0, 0, 16'h0, 16'h0, 1, 0, 16'h0002, 16'h0, 1, 0, 1, 16'h5555), "rlk_set");
    rst_i = 1'b0;
    m0_req = 1; m0_we = 0; m0_addr = 16'h0010; m1_req = 0;
    #1;
    chk("rlk m0_gnt", 32'(m0_gnt), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_i = 1'b1;
    step(mk(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'hBEEF), "rlk_post");

    // Build up starvation, then reset with an m0 read outstanding.
    starve_run(7, -1, "pre");
    rst_i = 1'b0;
    m0_req = 0; m1_req = 0;
    #1;
    chk("midrst m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("midrst m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("midrst gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_i = 1'b1;
    starve_run(10, 8, "post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
